tlu_emulator: RTL and testbench

Emulates the TLU (trigger logic unit) side of the EUDET-style trigger handshake, for loopback tests of the DUT readout's TLU controller and for bench tests without a real TLU. It issues triggers on `TLU_TRIGGER` and holds a `TRIGGER_BITS`-wide trigger number. In handshake mode it shifts that number out, clocked by the DUT-driven `TLU_CLOCK`, while the DUT holds `TLU_BUSY`. It sits on the test/bench board side of the RJ45 link: `TLU_TRIGGER`/`TLU_RESET` feed the DUT firmware, and `TLU_BUSY`/`TLU_CLOCK` come back from it.

---
 rtl/tlu_emulator_pkg.sv | 23 ++
 rtl/tlu_emu_input_sync.sv | 33 +++
 rtl/tlu_emulator.sv | 179 +++++++++++++++++
 tb/tb_tlu_emulator.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_emulator_pkg.sv
// Shared state encoding and default parameter values for the TLU emulator.
// No logic; imported by the emulator top.
// No flow control.
package tlu_emulator_pkg;

    localparam int DEF_TRIGGER_BITS   = 15;
    localparam int DEF_TIMEOUT_CYCLES = 1023;
    localparam int DEF_PULSE_CYCLES   = 4;
    localparam int DEF_RESET_CYCLES   = 8;

    // Wide enough for the largest allowed timeout (65535)
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET_PULSE,
        ST_PULSE,
        ST_WAIT_BUSY,
        ST_SHIFT,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/tlu_emu_input_sync.sv
// 2-FF synchronizer for an asynchronous line, with edge detect on the synced value.
// Latency: level 2 cycles; rise/fall valid in the same cycle the synced level changes.
// No backpressure; edges are single-cycle strobes.
module tlu_emu_input_sync (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_q <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~sync_q;
    assign fall  = ~sync & sync_q;

endmodule

// File: rtl/tlu_emulator.sv
// EUDET-style TLU emulator: trigger pulse or busy/clock handshake shifting out the trigger number.
// Latency: START -> TLU_TRIGGER 1 cycle; TLU_BUSY/TLU_CLOCK pin -> TLU_TRIGGER 3 cycles.
// START while not ready is dropped and counted in SKIPPED; RESET_ID is held until IDLE.
module tlu_emulator
    import tlu_emulator_pkg::*;
#(
    parameter int TRIGGER_BITS   = DEF_TRIGGER_BITS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    HANDSHAKE_MODE,
    input  logic                    START,
    input  logic                    RESET_ID,
    output logic                    TLU_TRIGGER,
    output logic                    TLU_RESET,
    input  logic                    TLU_BUSY,
    input  logic                    TLU_CLOCK,
    output logic [TRIGGER_BITS-1:0] TRIGGER_ID,
    output logic                    DONE,
    output logic [7:0]              SKIPPED,
    output logic                    TIMEOUT_ERR,
    output logic                    ACTIVE
);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [TRIGGER_BITS-1:0] shift_dat;
    logic                    reset_pend;

    logic busy_lvl, busy_rise, busy_fall;
    logic clk_lvl, clk_rise, clk_fall;
    logic unused_sync;

    tlu_emu_input_sync u_busy_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (TLU_BUSY),
        .level    (busy_lvl),
        .rise     (busy_rise),
        .fall     (busy_fall)
    );

    tlu_emu_input_sync u_clock_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (TLU_CLOCK),
        .level    (clk_lvl),
        .rise     (clk_rise),
        .fall     (clk_fall)
    );

    assign unused_sync = busy_rise ^ clk_lvl;

    logic reset_req;
    logic start_ok;
    logic clk_edge;
    logic timeout_hit;

    assign reset_req   = reset_pend | RESET_ID;
    assign start_ok    = (state == ST_IDLE) && !reset_req && !busy_lvl;
    assign clk_edge    = clk_rise | clk_fall;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            shift_dat   <= '0;
            reset_pend  <= 1'b0;
            TLU_TRIGGER <= 1'b0;
            TLU_RESET   <= 1'b0;
            TRIGGER_ID  <= '0;
            DONE        <= 1'b0;
            SKIPPED     <= '0;
            TIMEOUT_ERR <= 1'b0;
            ACTIVE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            // Requests outside IDLE merge into one; IDLE clears it below when served
            if (RESET_ID) begin
                reset_pend <= 1'b1;
            end
            if (START && !start_ok && SKIPPED != 8'hFF) begin
                SKIPPED <= SKIPPED + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (reset_req) begin
                        reset_pend <= 1'b0;
                        TLU_RESET  <= 1'b1;
                        cnt        <= '0;
                        ACTIVE     <= 1'b1;
                        state      <= ST_RESET_PULSE;
                    end else if (START && !busy_lvl) begin
                        shift_dat   <= TRIGGER_ID;
                        TLU_TRIGGER <= 1'b1;
                        cnt         <= '0;
                        ACTIVE      <= 1'b1;
                        state       <= HANDSHAKE_MODE ? ST_WAIT_BUSY : ST_PULSE;
                    end
                end

                ST_RESET_PULSE: begin
                    if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
                        TLU_RESET  <= 1'b0;
                        TRIGGER_ID <= '0;
                        ACTIVE     <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_PULSE: begin
                    if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                        TLU_TRIGGER <= 1'b0;
                        state       <= ST_FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WAIT_BUSY: begin
                    if (busy_lvl) begin
                        TLU_TRIGGER <= 1'b0;
                        cnt         <= '0;
                        state       <= ST_SHIFT;
                    end else if (timeout_hit) begin
                        // No busy answer: abandon this number without DONE
                        TIMEOUT_ERR <= 1'b1;
                        TLU_TRIGGER <= 1'b0;
                        TRIGGER_ID  <= TRIGGER_ID + 1'b1;
                        ACTIVE      <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (busy_fall) begin
                        TLU_TRIGGER <= 1'b0;
                        state       <= ST_FINISH;
                    end else if (timeout_hit && !clk_edge) begin
                        TIMEOUT_ERR <= 1'b1;
                        TLU_TRIGGER <= 1'b0;
                        state       <= ST_FINISH;
                    end else begin
                        // Zeros shift in, so edges past the last bit drive 0
                        if (clk_rise) begin
                            TLU_TRIGGER <= shift_dat[0];
                            shift_dat   <= shift_dat >> 1;
                        end
                        cnt <= clk_edge ? '0 : cnt + 1'b1;
                    end
                end

                ST_FINISH: begin
                    TLU_TRIGGER <= 1'b0;
                    TRIGGER_ID  <= TRIGGER_ID + 1'b1;
                    DONE        <= 1'b1;
                    ACTIVE      <= 1'b0;
                    state       <= ST_IDLE;
                end

                default: begin
                    TLU_TRIGGER <= 1'b0;
                    ACTIVE      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlu_emulator.sv
// Scoreboard bench for tlu_emulator: randomized simple/handshake triggers against a queue-based model.
module tb_tlu_emulator;

    localparam int TB      = 15;
    localparam int ID_MOD  = 1 << TB;
    localparam int PULSE   = 4;
    localparam int RSTLEN  = 8;
    localparam int TO      = 20;

    logic        CLK, RST, HANDSHAKE_MODE, START, RESET_ID, TLU_BUSY, TLU_CLOCK;
    logic        TLU_TRIGGER, TLU_RESET, DONE, TIMEOUT_ERR, ACTIVE;
    logic [TB-1:0] TRIGGER_ID;
    logic [7:0]  SKIPPED;

    logic        START4;
    logic        TLU_TRIGGER4, TLU_RESET4, DONE4, TIMEOUT_ERR4, ACTIVE4;
    logic [3:0]  TRIGGER_ID4;
    logic [7:0]  SKIPPED4;
    logic        zero_in;

    tlu_emulator #(.TRIGGER_BITS(TB), .TIMEOUT_CYCLES(TO), .PULSE_CYCLES(PULSE), .RESET_CYCLES(RSTLEN)) dut (
        .CLK(CLK), .RST(RST), .HANDSHAKE_MODE(HANDSHAKE_MODE), .START(START), .RESET_ID(RESET_ID),
        .TLU_TRIGGER(TLU_TRIGGER), .TLU_RESET(TLU_RESET), .TLU_BUSY(TLU_BUSY), .TLU_CLOCK(TLU_CLOCK),
        .TRIGGER_ID(TRIGGER_ID), .DONE(DONE), .SKIPPED(SKIPPED), .TIMEOUT_ERR(TIMEOUT_ERR), .ACTIVE(ACTIVE)
    );

    tlu_emulator #(.TRIGGER_BITS(4), .TIMEOUT_CYCLES(TO), .PULSE_CYCLES(2), .RESET_CYCLES(RSTLEN)) dut4 (
        .CLK(CLK), .RST(RST), .HANDSHAKE_MODE(zero_in), .START(START4), .RESET_ID(zero_in),
        .TLU_TRIGGER(TLU_TRIGGER4), .TLU_RESET(TLU_RESET4), .TLU_BUSY(zero_in), .TLU_CLOCK(zero_in),
        .TRIGGER_ID(TRIGGER_ID4), .DONE(DONE4), .SKIPPED(SKIPPED4), .TIMEOUT_ERR(TIMEOUT_ERR4), .ACTIVE(ACTIVE4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int id;     // TRIGGER_ID expected alongside DONE
        int width;  // TLU_TRIGGER high time, -1 = not checked
        int data;   // word the DUT model should have received, -1 = none
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_id = 0;
    int   exp_skip = 0;
    int   exp_terr = 0;
    int   done_cnt = 0;
    int   rx_word = 0;
    int   trig_run = 0;
    int   last_w = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic int sat_skip(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Monitor: measures trigger pulse widths and scores every DONE against the queue
    always @(negedge CLK) begin
        exp_t e;
        if (TLU_TRIGGER) trig_run++;
        else if (trig_run > 0) begin
            last_w   = trig_run;
            trig_run = 0;
        end
        if (DONE) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("done_id", TRIGGER_ID, e.id);
                check("done_skipped", SKIPPED, exp_skip);
                check("done_timeout_err", TIMEOUT_ERR, exp_terr);
                check("done_active", ACTIVE, 0);
                if (e.width >= 0) check("pulse_width", last_w, e.width);
                if (e.data >= 0) check("hs_data", rx_word, e.data);
            end
        end
    end

    task automatic wait_done(input int budget);
        int c0;
        int n;
        c0 = done_cnt;
        n  = 0;
        while (done_cnt == c0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == c0) begin
            checks++;
            errors++;
            $display("FAIL done_wait actual=no_done required=done at %0t", $time);
        end
    endtask

    task automatic simple_trig();
        exp_t e;
        HANDSHAKE_MODE = 1'b0;
        exp_id  = (exp_id + 1) % ID_MOD;
        e.id    = exp_id;
        e.width = PULSE;
        e.data  = -1;
        exp_q.push_back(e);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_latency", TLU_TRIGGER, 1);
        wait_done(40);
    endtask

    // DUT-side handshake model: raise busy, clock nclk bits, sample on falling clock
    task automatic hs_trig(input int nclk, input bit inject);
        exp_t e;
        int   rx, hi, lo, bits;
        bits    = (nclk < TB) ? nclk : TB;
        e.data  = exp_id & ((1 << bits) - 1);
        exp_id  = (exp_id + 1) % ID_MOD;
        e.id    = exp_id;
        e.width = -1;
        exp_q.push_back(e);
        HANDSHAKE_MODE = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("hs_trigger_high", TLU_TRIGGER, 1);
        tick($urandom_range(0, 5));
        TLU_BUSY = 1'b1;
        tick(3);
        check("hs_trigger_low", TLU_TRIGGER, 0);
        rx = 0;
        for (int i = 0; i < nclk; i++) begin
            hi = $urandom_range(4, 6);
            lo = $urandom_range(4, 6);
            TLU_CLOCK = 1'b1;
            tick(hi);
            rx = rx | (int'(TLU_TRIGGER) << i);
            TLU_CLOCK = 1'b0;
            if (inject && i == 3) begin
                RESET_ID = 1'b1;
                tick();
                RESET_ID = 1'b0;
                START = 1'b1;
                tick();
                START = 1'b0;
                exp_skip = sat_skip(exp_skip + 1);
                tick(lo - 2);
                check("reset_deferred", TLU_RESET, 0);
            end else begin
                tick(lo);
            end
        end
        rx_word  = rx;
        TLU_BUSY = 1'b0;
        wait_done(40);
    endtask

    task automatic measure_reset();
        int w, n;
        n = 0;
        while (!TLU_RESET && n < 20) begin
            tick();
            n++;
        end
        w = 0;
        while (TLU_RESET && w < 50) begin
            tick();
            w++;
        end
        exp_id = 0;
        check("reset_width", w, RSTLEN);
        check("reset_clears_id", TRIGGER_ID, exp_id);
    endtask

    initial begin
        int w, c0, n, exp4;
        RST = 1'b1; HANDSHAKE_MODE = 1'b0; START = 1'b0; RESET_ID = 1'b0;
        TLU_BUSY = 1'b0; TLU_CLOCK = 1'b0; START4 = 1'b0; zero_in = 1'b0;
        tick(3);
        check("rst_trigger", TLU_TRIGGER, 0);
        check("rst_reset", TLU_RESET, 0);
        check("rst_id", TRIGGER_ID, 0);
        check("rst_done", DONE, 0);
        check("rst_skipped", SKIPPED, 0);
        check("rst_timeout_err", TIMEOUT_ERR, 0);
        check("rst_active", ACTIVE, 0);
        RST = 1'b0;
        tick(2);

        // Randomized mix of simple pulses, handshakes and reset requests
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 7))
                0: begin
                    RESET_ID = 1'b1;
                    tick();
                    RESET_ID = 1'b0;
                    measure_reset();
                end
                1, 2, 3: simple_trig();
                default: hs_trig($urandom_range(12, 17), 1'b0);
            endcase
            tick($urandom_range(0, 3));
        end

        // Busy never answers
        HANDSHAKE_MODE = 1'b1;
        c0 = done_cnt;
        START = 1'b1;
        tick();
        START = 1'b0;
        w = 0;
        while (TLU_TRIGGER && w < 100) begin
            tick();
            w++;
        end
        exp_id   = (exp_id + 1) % ID_MOD;
        exp_terr = 1;
        check("timeout_width", w, TO);
        tick(3);
        check("timeout_err", TIMEOUT_ERR, exp_terr);
        check("timeout_id", TRIGGER_ID, exp_id);
        check("timeout_no_done", done_cnt, c0);

        // Reset request and START during SHIFT
        hs_trig(16, 1'b1);
        measure_reset();
        check("skip_during_shift", SKIPPED, exp_skip);

        // Saturation with busy held high
        TLU_BUSY = 1'b1;
        tick(3);
        START = 1'b1;
        tick(300);
        START = 1'b0;
        tick();
        exp_skip = sat_skip(exp_skip + 300);
        check("skip_saturate", SKIPPED, exp_skip);
        check("busy_blocks_start", ACTIVE, 0);
        TLU_BUSY = 1'b0;
        tick(3);

        // Preload 0x5A5 then shift it out
        while (exp_id != 'h5A5) simple_trig();
        hs_trig(16, 1'b0);
        check("hs_5a5_word", rx_word, 'h5A5);
        check("hs_5a6_id", TRIGGER_ID, 'h5A6);

        // RST in the middle of a shift, right after bit 5
        HANDSHAKE_MODE = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick(2);
        TLU_BUSY = 1'b1;
        tick(4);
        for (int i = 0; i < 6; i++) begin
            TLU_CLOCK = 1'b1;
            tick(5);
            TLU_CLOCK = 1'b0;
            tick(5);
        end
        check("pre_rst_bit5", TLU_TRIGGER, (exp_id >> 5) & 1);
        RST = 1'b1;
        TLU_BUSY = 1'b0;
        tick();
        exp_id = 0; exp_skip = 0; exp_terr = 0;
        check("midrst_trigger", TLU_TRIGGER, 0);
        check("midrst_reset", TLU_RESET, 0);
        check("midrst_id", TRIGGER_ID, exp_id);
        check("midrst_done", DONE, 0);
        check("midrst_skipped", SKIPPED, exp_skip);
        check("midrst_timeout_err", TIMEOUT_ERR, exp_terr);
        check("midrst_active", ACTIVE, 0);
        RST = 1'b0;
        tick(3);
        simple_trig();

        // 4-bit instance: 17 triggers wrap the number to 1
        exp4 = 0;
        for (int k = 0; k < 17; k++) begin
            START4 = 1'b1;
            tick();
            START4 = 1'b0;
            n = 0;
            while (!DONE4 && n < 30) begin
                tick();
                n++;
            end
            exp4 = (exp4 + 1) % 16;
            check("wrap_done_seen", DONE4, 1);
            check("wrap_id", TRIGGER_ID4, exp4);
            tick();
        end

        tick(5);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
